// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, instruction-memory write bus out
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    // master: byte source / memory sink; slave: the loader itself
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream image loader into instruction memory
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          error
);
    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [32:0]         CAP     = 33'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] IDX_ONE = 1;

    state_t                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
    logic [31:0]           len_q, len_d;
    logic [31:0]           word_q, word_d;
    logic [7:0]            csum_q, csum_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  accept;

    assign accept = bus.rx_valid && rx_ready_q;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_idx_d  = word_idx_q;
        len_d       = len_q;
        word_d      = word_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = LEN;
                    byte_cnt_d = '0;
                    word_idx_d = '0;
                    csum_d     = '0;
                    len_d      = '0;
                end
            end
            LEN: begin
                if (accept) begin
                    len_d      = {bus.rx_data, len_q[31:8]};
                    csum_d     = csum_q ^ bus.rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if ({1'b0, len_d} > CAP)
                            state_d = ERR;
                        else if (len_d == 32'd0)
                            state_d = CSUM;
                        else
                            state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    word_d     = {bus.rx_data, word_q[31:8]};
                    csum_d     = csum_q ^ bus.rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // write is registered, so it lands on the next cycle
                        mem_we_d    = 1'b1;
                        mem_addr_d  = 32'(word_idx_q) << 2;
                        mem_wdata_d = word_d;
                        word_idx_d  = word_idx_q + IDX_ONE;
                        if (32'(word_idx_d) == len_q)
                            state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (accept)
                    state_d = (bus.rx_data == csum_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase

        rx_ready_d  = (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
        busy_d      = rx_ready_d;
        done_d      = (state_d == DONE);
        error_d     = (state_d == ERR);
        cpu_reset_d = (state_d != DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            word_idx_q  <= '0;
            len_q       <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            rx_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_idx_q  <= word_idx_d;
            len_q       <= len_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            rx_ready_q  <= rx_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_reset     = cpu_reset_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset, start;
    logic cpu_reset, busy, done, error;

    imem_loader_if bus();

    imem_loader #(.ADDR_WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus.slave),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int acc    = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  good[$], bad[$], head[$], tail[$], empty[$], big[$], over[$];

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
        end
        if (bus.rx_valid && bus.rx_ready)
            acc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        if (n >= 20) chk("send_timeout", 32'(n), 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit bp);
        foreach (f[i]) begin
            if (bp && $urandom_range(0, 1) == 1) begin
                bus.rx_valid = 1'b0;
                tick($urandom_range(1, 3));
            end
            send(f[i]);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        acc = 0;
    endtask

    task automatic check_good(input string tag);
        chk({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
        chk({tag, "_a0"}, wr_addr[0], 32'h0);
        chk({tag, "_d0"}, wr_data[0], 32'h0010_0513);
        chk({tag, "_a1"}, wr_addr[1], 32'h4);
        chk({tag, "_d1"}, wr_data[1], 32'h0020_0593);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_acc"}, 32'(acc), 32'd13);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        good  = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                  8'h93, 8'h05, 8'h20, 8'h00, 8'hB2};
        bad   = good;
        bad[12] = 8'h00;
        head  = good[0:5];
        tail  = good[6:12];
        empty = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        over  = '{8'h11, 8'h00, 8'h00, 8'h00};
        big   = '{8'h10, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 64; i++) big.push_back(8'(i));
        big.push_back(8'h10);   // XOR of 0..63 is zero, leaving only the length byte

        reset = 1'b1;
        start = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        tick(2);
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        tick(1);

        // nominal load
        pulse_start();
        chk("s1_busy", 32'(busy), 32'd1);
        chk("s1_rx_ready", 32'(bus.rx_ready), 32'd1);
        chk("s1_cpu_reset", 32'(cpu_reset), 32'd1);
        clear_log();
        send_frame(good, 1'b0);
        tick(2);
        check_good("s1");

        // bad checksum, then retry
        pulse_start();
        chk("s2_done_clr", 32'(done), 32'd0);
        chk("s2_cpu_reset_set", 32'(cpu_reset), 32'd1);
        clear_log();
        send_frame(bad, 1'b0);
        tick(2);
        chk("s2_nwr", 32'(wr_addr.size()), 32'd2);
        chk("s2_d1", wr_data[1], 32'h0020_0593);
        chk("s2_error", 32'(error), 32'd1);
        chk("s2_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("s2_done", 32'(done), 32'd0);
        pulse_start();
        chk("s2_error_clr", 32'(error), 32'd0);
        clear_log();
        send_frame(good, 1'b0);
        tick(2);
        check_good("s2r");

        // empty image
        pulse_start();
        clear_log();
        send_frame(empty, 1'b0);
        tick(2);
        chk("s3_nwr", 32'(wr_addr.size()), 32'd0);
        chk("s3_done", 32'(done), 32'd1);

        // capacity: N = 17 rejected, N = 16 accepted
        pulse_start();
        clear_log();
        send_frame(over, 1'b0);
        chk("s4_err", 32'(error), 32'd1);
        chk("s4_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("s4_busy", 32'(busy), 32'd0);
        tick(2);
        chk("s4_nwr_over", 32'(wr_addr.size()), 32'd0);
        pulse_start();
        send_frame(big, 1'b0);
        tick(2);
        chk("s4_nwr", 32'(wr_addr.size()), 32'd16);
        chk("s4_d0", wr_data[0], 32'h0302_0100);
        chk("s4_a15", wr_addr[15], 32'h3C);
        chk("s4_d15", wr_data[15], 32'h3F3E_3D3C);
        chk("s4_done", 32'(done), 32'd1);

        // backpressure, stray rx_valid in DONE, start while busy
        clear_log();
        bus.rx_data  = 8'h55;
        bus.rx_valid = 1'b1;
        tick(3);
        bus.rx_valid = 1'b0;
        chk("s5_acc_done", 32'(acc), 32'd0);
        chk("s5_still_done", 32'(done), 32'd1);
        pulse_start();
        send_frame(head, 1'b1);
        pulse_start();
        chk("s5_busy_start", 32'(busy), 32'd1);
        send_frame(tail, 1'b1);
        tick(2);
        check_good("s5");

        // reset mid-load
        pulse_start();
        clear_log();
        send_frame(head, 1'b0);
        reset = 1'b1;
        tick(1);
        chk("s6_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("s6_mem_we", 32'(bus.mem_we), 32'd0);
        chk("s6_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("s6_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        acc = 0;
        bus.rx_data  = 8'hAA;
        bus.rx_valid = 1'b1;
        tick(3);
        bus.rx_valid = 1'b0;
        tick(3);
        chk("s6_acc_idle", 32'(acc), 32'd0);
        chk("s6_nwr", 32'(wr_addr.size()), 32'd0);
        pulse_start();
        clear_log();
        send_frame(good, 1'b0);
        tick(2);
        check_good("s6r");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: writer side of the instruction memory the CPU core fetches from.
- Receives a framed image over a valid/ready byte stream (fed by the UART RX path) and assembles little-endian 32-bit words.
- Writes the words sequentially into instruction memory and holds the CPU in reset until a complete, checksum-verified image is loaded.

Parameters:
- ADDR_WIDTH, 10, instruction memory word-address bits; capacity is 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; ignored while busy.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  32  byte address of the write (word index × 4).
- mem_wdata  output  32  word to write.
- cpu_reset  output  1  holds the CPU core in reset.
- busy  output  1  load in progress.
- done  output  1  image loaded and verified.
- error  output  1  load failed.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - state=IDLE.
  - rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_reset=1, busy=0, done=0, error=0.
  - Internal counters and checksum are 0.
- Handshake: a byte is consumed on a cycle where rx_valid && rx_ready. rx_ready=1 only in LEN, DATA and CSUM.
- Frame format:
  - 4-byte word count N, little-endian.
  - N words, 4 bytes each, little-endian.
  - 1 checksum byte equal to the XOR of all preceding frame bytes (length and data).
- State IDLE:
  - cpu_reset=1.
  - start → LEN; clear byte counter, word index and running XOR.
- State LEN:
  - Collect 4 bytes into N; every byte is XORed into the checksum.
  - After the 4th byte: N > 2^ADDR_WIDTH → ERR; N == 0 → CSUM; otherwise → DATA.
  - N == 2^ADDR_WIDTH is legal.
- State DATA:
  - Byte k of each word (k=0..3) goes to bits [8k+7:8k].
  - On the cycle after the 4th byte is accepted: mem_we=1 for exactly one cycle, mem_addr = word_idx×4, mem_wdata = assembled word. word_idx then increments.
  - rx_ready stays high through the write cycle, so a byte may be accepted in the same cycle as mem_we.
  - After word N-1 is accepted → CSUM.
- State CSUM:
  - Accept 1 byte.
  - Equal to running XOR → DONE; otherwise → ERR.
  - The final data word's mem_we pulse is still issued, on the first CSUM cycle.
- State DONE:
  - done=1, cpu_reset=0, busy=0, rx_ready=0.
  - start → LEN, with cpu_reset=1 and done=0 from the next cycle.
- State ERR:
  - error=1, cpu_reset=1, rx_ready=0.
  - start → LEN with error cleared.
- busy=1 exactly in LEN, DATA and CSUM. start while busy has no effect.
- rx_valid outside LEN/DATA/CSUM is ignored and no byte is consumed.
- Reset mid-load: all outputs return to reset values on the next edge and any pending mem_we is dropped. Words already written are not erased.
- Width rules:
  - word_idx is ADDR_WIDTH+1 bits.
  - mem_addr is word_idx zero-extended and shifted left by 2.
  - The length compare uses all 32 bits of N.

Test Plan:
1. Nominal load: start, then bytes 02 00 00 00 13 05 10 00 93 05 20 00 B2 → mem_we pulses with addr 0x0 / wdata 0x00100513 and addr 0x4 / wdata 0x00200593; then done=1, cpu_reset=0, busy=0.
2. Bad checksum: same stream with last byte 0x00 → both words written, then error=1, cpu_reset=1, done=0. A following start plus the valid stream → done=1.
3. Empty image: bytes 00 00 00 00 00 → no mem_we; done=1.
4. Capacity, with ADDR_WIDTH=4:
   - N=17 (11 00 00 00) → ERR right after the 4th length byte; no mem_we; rx_ready=0.
   - N=16 with a correct checksum → 16 writes, last at addr 0x3C; done=1.
5. Backpressure: scenario 1 with rx_valid randomly deasserted between bytes, plus rx_valid pulses in IDLE and DONE → identical writes and final state; no bytes consumed outside LEN/DATA/CSUM; start pulses while busy ignored.
6. Reset mid-load: assert reset after the 6th byte of scenario 1 → next cycle rx_ready=0, mem_we=0, cpu_reset=1, busy=0, no further writes. A full reload then completes with done=1.
